muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO result registers. It is the parametrised successor to the single-cycle ALU and sits beside it in the EX stage. It executes MIPS MULT/MULTU/DIV/DIVU plus MTHI/MTLO. Busy status drives the hazard unit, which stalls MFHI/MFLO and further mult/div issue.

---
 rtl/muldiv_unit_if.sv | 32 +++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Issue/result bundle between EX-stage control and muldiv_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    muldiv_unit_if.slave bus
);

    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_LAST    = CW'(WIDTH - 1);
    localparam logic [2:0]    c_OP_MTHI = 3'd4;
    localparam logic [2:0]    c_OP_MTLO = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_divzero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_idle_go;
    logic             w_accept;
    logic             w_mt;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_idle_go = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_accept  = w_idle_go && (bus.op <= 3'd3);
    assign w_mt      = w_idle_go && ((bus.op == c_OP_MTHI) || (bus.op == c_OP_MTLO));
    // Even opcodes among 0..3 (MULT, DIV) are the signed variants.
    assign w_signed  = !bus.op[0];
    assign w_a_neg   = w_signed && bus.a[WIDTH-1];
    assign w_b_neg   = w_signed && bus.b[WIDTH-1];
    assign w_abs_a   = w_a_neg ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    assign w_abs_b   = w_b_neg ? ({WIDTH{1'b0}} - bus.b) : bus.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.flush || (r_cnt == c_LAST)) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_upper_nx;
    logic [WIDTH-1:0] w_lower_nx;

    // Multiply: shift-add on {upper,lower}, multiplier consumed from lower LSB.
    // Divide: restoring, dividend shifted out of lower, quotient shifted in.
    assign w_mul_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_upper, r_lower[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

    always_comb begin
        w_upper_nx = w_mul_sum[WIDTH:1];
        w_lower_nx = {w_mul_sum[0], r_lower[WIDTH-1:1]};
        if (r_is_div) begin
            w_upper_nx = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_lower_nx = {r_lower[WIDTH-2:0], w_div_ge};
        end
    end

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_wb;
    logic [WIDTH-1:0]   w_lo_wb;

    assign w_prod     = {w_upper_nx, w_lower_nx};
    assign w_prod_fix = r_neg_q ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;
    // Divide-by-zero: the restoring loop already leaves rem = |a|, so only the
    // quotient needs forcing; negating rem by a's sign recovers a exactly.
    assign w_quot     = r_divzero ? {WIDTH{1'b1}}
                      : (r_neg_q ? ({WIDTH{1'b0}} - w_lower_nx) : w_lower_nx);
    assign w_rem      = r_neg_r ? ({WIDTH{1'b0}} - w_upper_nx) : w_upper_nx;
    assign w_hi_wb    = r_is_div ? w_rem  : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_wb    = r_is_div ? w_quot : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_upper   <= '0;
            r_lower   <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt     <= '0;
                r_upper   <= '0;
                r_lower   <= bus.op[1] ? w_abs_a : w_abs_b;
                r_opnd    <= bus.op[1] ? w_abs_b : w_abs_a;
                r_is_div  <= bus.op[1];
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_divzero <= bus.op[1] && (bus.b == '0);
            end else if ((r_state == S_CALC) && !bus.flush) begin
                r_upper <= w_upper_nx;
                r_lower <= w_lower_nx;
                if (r_cnt == c_LAST) begin
                    r_hi   <= w_hi_wb;
                    r_lo   <= w_lo_wb;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (w_mt) begin
                if (bus.op == c_OP_MTHI) begin
                    r_hi <= bus.a;
                end else begin
                    r_lo <= bus.a;
                end
            end
        end
    end

    assign bus.busy = (r_state == S_CALC);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus32();
    muldiv_unit_if #(.WIDTH(8))  bus8();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi [2];
    logic [31:0] exp_lo [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int k, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
        if (k == 0) begin
            bus32.start = s; bus32.op = op; bus32.a = a; bus32.b = b; bus32.flush = fl;
        end else begin
            bus8.start = s; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.flush = fl;
        end
    endtask

    task automatic sample(input int k, output logic bz, output logic dn,
                          output logic [31:0] h, output logic [31:0] l);
        if (k == 0) begin
            bz = bus32.busy; dn = bus32.done; h = bus32.hi; l = bus32.lo;
        end else begin
            bz = bus8.busy; dn = bus8.done; h = {24'd0, bus8.hi}; l = {24'd0, bus8.lo};
        end
    endtask

    // Reference: plain integer arithmetic on sign-/zero-extended operands.
    task automatic model(input int w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned ua   = {32'd0, a} & mask;
        longint unsigned ub   = {32'd0, b} & mask;
        longint          sa   = a[w-1] ? longint'(ua | ~mask) : longint'(ua);
        longint          sb   = b[w-1] ? longint'(ub | ~mask) : longint'(ub);
        longint          minv = -(longint'(1) << (w - 1));
        longint          p;
        longint unsigned pu;
        longint unsigned rh, rl;
        rh = 0; rl = 0;
        case (op)
            3'd0: begin p  = sa * sb; rh = longint'(p) >> w; rl = p; end
            3'd1: begin pu = ua * ub; rh = pu >> w;          rl = pu; end
            3'd2: begin
                if (ub == 0)                       begin rl = mask; rh = ua; end
                else if (sa == minv && sb == -1)   begin rl = longint'(minv); rh = 0; end
                else                               begin rl = sa / sb; rh = sa % sb; end
            end
            default: begin
                if (ub == 0) begin rl = mask; rh = ua; end
                else         begin rl = ua / ub; rh = ua % ub; end
            end
        endcase
        hi = 32'(rh & mask);
        lo = 32'(rl & mask);
    endtask

    task automatic run_op(input int k, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at);
        int          w = (k == 0) ? 32 : 8;
        int          n = -1;
        logic        busy_ok = 1'b1;
        logic        bz, dn;
        logic [31:0] h, l, eh, el;
        model(w, op, a, b, eh, el);
        @(negedge clk); drive(k, 1'b1, op, a, b, 1'b0);
        @(negedge clk); drive(k, 1'b0, op, a, b, 1'b0);
        for (int i = 0; i < 100; i++) begin
            sample(k, bz, dn, h, l);
            if (dn) begin n = i; break; end
            if (!bz) busy_ok = 1'b0;
            if (i == poke_at) drive(k, 1'b1, 3'd0, 32'h5, 32'h9, 1'b0);
            @(negedge clk);
            drive(k, 1'b0, op, a, b, 1'b0);
        end
        chk($sformatf("latency w%0d op%0d", w, op), 64'(n), 64'(w));
        chk("busy_during", {63'd0, busy_ok}, 64'd1);
        chk("busy_in_done", {63'd0, bz}, 64'd0);
        chk($sformatf("hi w%0d op%0d a=%0h b=%0h", w, op, a, b), {32'd0, h}, {32'd0, eh});
        chk($sformatf("lo w%0d op%0d a=%0h b=%0h", w, op, a, b), {32'd0, l}, {32'd0, el});
        @(negedge clk); sample(k, bz, dn, h, l);
        chk("done_one_cycle", {63'd0, dn}, 64'd0);
        exp_hi[k] = eh; exp_lo[k] = el;
    endtask

    task automatic mt(input int k, input logic [2:0] op, input logic [31:0] a);
        logic        bz, dn;
        logic [31:0] h, l;
        logic [31:0] av = (k == 0) ? a : {24'd0, a[7:0]};
        @(negedge clk); drive(k, 1'b1, op, a, 32'd0, 1'b0);
        @(negedge clk); drive(k, 1'b0, op, a, 32'd0, 1'b0);
        if (op == 3'd4) exp_hi[k] = av; else exp_lo[k] = av;
        sample(k, bz, dn, h, l);
        chk("mt_hi", {32'd0, h}, {32'd0, exp_hi[k]});
        chk("mt_lo", {32'd0, l}, {32'd0, exp_lo[k]});
        chk("mt_busy", {62'd0, bz, dn}, 64'd0);
    endtask

    task automatic run_flush(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int flush_at);
        logic        bz, dn;
        logic        any_done = 1'b0;
        logic [31:0] h, l;
        @(negedge clk); drive(0, 1'b1, op, a, b, 1'b0);
        @(negedge clk); drive(0, 1'b0, op, a, b, 1'b0);
        repeat (flush_at) @(negedge clk);
        drive(0, 1'b0, op, a, b, 1'b1);
        @(negedge clk); drive(0, 1'b0, op, a, b, 1'b0);
        sample(0, bz, dn, h, l);
        chk("flush_busy", {63'd0, bz}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            sample(0, bz, dn, h, l);
            if (dn) any_done = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_done", {63'd0, any_done}, 64'd0);
        chk("flush_hi", {32'd0, h}, {32'd0, exp_hi[0]});
        chk("flush_lo", {32'd0, l}, {32'd0, exp_lo[0]});
    endtask

    initial begin
        logic        bz, dn;
        logic [31:0] h, l;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
        repeat (3) @(negedge clk);
        sample(0, bz, dn, h, l);
        chk("rst_busy", {63'd0, bz}, 64'd0);
        chk("rst_done", {63'd0, dn}, 64'd0);
        chk("rst_hi", {32'd0, h}, 64'd0);
        chk("rst_lo", {32'd0, l}, 64'd0);
        rst_n = 1'b1;

        run_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3, -1);
        chk("mult_hi_const", {32'd0, bus32.hi}, 64'hFFFF_FFFF);
        chk("mult_lo_const", {32'd0, bus32.lo}, 64'hFFFF_FFFA);
        run_op(0, 3'd1, 32'hFFFF_FFFE, 32'd3, -1);
        chk("multu_hi_const", {32'd0, bus32.hi}, 64'h2);
        run_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_lo_const", {32'd0, bus32.lo}, 64'hFFFF_FFFD);
        chk("div_hi_const", {32'd0, bus32.hi}, 64'hFFFF_FFFF);
        run_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("ovf_lo_const", {32'd0, bus32.lo}, 64'h8000_0000);
        run_op(0, 3'd3, 32'd7, 32'd0, -1);
        chk("divu0_lo_const", {32'd0, bus32.lo}, 64'hFFFF_FFFF);
        chk("divu0_hi_const", {32'd0, bus32.hi}, 64'd7);
        run_op(0, 3'd2, 32'hFFFF_FFF3, 32'd0, -1);

        run_flush(3'd3, 32'd100, 32'd7, 10);
        run_op(0, 3'd3, 32'd1000, 32'd7, 5);

        // flush wins over a simultaneous start in IDLE
        @(negedge clk); drive(0, 1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
        @(negedge clk); drive(0, 1'b0, 3'd0, 32'd3, 32'd3, 1'b0);
        sample(0, bz, dn, h, l);
        chk("flush_start_busy", {63'd0, bz}, 64'd0);
        // reserved op is ignored
        @(negedge clk); drive(0, 1'b1, 3'd6, 32'hAA, 32'h55, 1'b0);
        @(negedge clk); drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        sample(0, bz, dn, h, l);
        chk("rsvd_busy", {63'd0, bz}, 64'd0);
        chk("rsvd_hi", {32'd0, h}, {32'd0, exp_hi[0]});
        chk("rsvd_lo", {32'd0, l}, {32'd0, exp_lo[0]});

        mt(0, 3'd5, 32'h1234);
        mt(0, 3'd4, 32'hCAFE_F00D);

        run_op(1, 3'd0, 32'h80, 32'h80, -1);
        run_op(1, 3'd2, 32'h80, 32'hFF, -1);
        run_op(1, 3'd2, 32'hF9, 32'h02, -1);
        mt(1, 3'd4, 32'h5A);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 3 == 1) rb = 32'($urandom_range(1, 300)) ^ {32{ra[31]}};
            if (rop >= 3'd4) mt(0, rop, ra); else run_op(0, rop, ra, rb, -1);
        end
        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (rop >= 3'd4) mt(1, rop, ra); else run_op(1, rop, ra, rb, -1);
        end

        // asynchronous reset in the middle of a multiply
        @(negedge clk); drive(0, 1'b1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        @(negedge clk); drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 sample(0, bz, dn, h, l);
        chk("rst_mid_busy", {63'd0, bz}, 64'd0);
        chk("rst_mid_hi", {32'd0, h}, 64'd0);
        chk("rst_mid_lo", {32'd0, l}, 64'd0);
        chk("rst_mid_hi8", {56'd0, bus8.hi}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        exp_hi[0] = '0; exp_lo[0] = '0;
        run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
